// File: rtl/xbus_cycle_seq.sv
// Bus-cycle sequencer: interlocked REQ/ACK handshake with address-settle delay and
// timeouts, producing a 6-bit status word plus a one-cycle status-register load strobe.
module xbus_cycle_seq #(
    parameter int SETTLE  = 2,
    parameter int TMO_MAX = 200,
    parameter int TMO_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_wr,
    input  logic       i_abort,
    input  logic       i_bus_ack,
    input  logic       i_bus_par_err,
    output logic       o_busy,
    output logic       o_bus_req,
    output logic       o_bus_wr,
    output logic [5:0] o_sts,
    output logic       o_sts_ld
);

    // state    | meaning
    // IDLE     | waiting for START
    // SETUP    | address settle delay before BUS_REQ
    // REQ      | BUS_REQ high, waiting for ACK or timeout
    // RELEASE  | BUS_REQ low, waiting for ACK to drop
    // REPORT   | one cycle, status word loaded
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    localparam int                SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SET_W-1:0]   r_settle;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_done, r_nxm, r_perr, r_abt, r_stuck;
    logic               w_done_nxt, w_nxm_nxt, w_perr_nxt, w_abt_nxt, w_stuck_nxt;
    logic               w_accept;
    logic               w_tmo_hit;
    logic               w_busy_nxt, w_req_nxt, w_ld_nxt, w_bus_wr_nxt;
    logic [5:0]         w_sts_nxt;

    assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_settle  <= '0;
            r_tmo     <= '0;
            r_done    <= 1'b0;
            r_nxm     <= 1'b0;
            r_perr    <= 1'b0;
            r_abt     <= 1'b0;
            r_stuck   <= 1'b0;
            o_busy    <= 1'b0;
            o_bus_req <= 1'b0;
            o_bus_wr  <= 1'b0;
            o_sts     <= 6'b0;
            o_sts_ld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_nxm   <= w_nxm_nxt;
            r_perr  <= w_perr_nxt;
            r_abt   <= w_abt_nxt;
            r_stuck <= w_stuck_nxt;

            if (r_state == ST_IDLE)
                r_settle <= SET_LOAD;
            else if (r_state == ST_SETUP && r_settle != '0)
                r_settle <= r_settle - 1'b1;

            // Timeout counter restarts on every entry to REQ/RELEASE; leaving on hit prevents wrap.
            if ((r_state == ST_REQ || r_state == ST_RELEASE) && w_state_nxt == r_state)
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;

            o_busy    <= w_busy_nxt;
            o_bus_req <= w_req_nxt;
            o_bus_wr  <= w_bus_wr_nxt;
            o_sts     <= w_sts_nxt;
            o_sts_ld  <= w_ld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_nxm_nxt   = r_nxm;
        w_perr_nxt  = r_perr;
        w_abt_nxt   = r_abt;
        w_stuck_nxt = r_stuck;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_done_nxt  = 1'b0;
                    w_nxm_nxt   = 1'b0;
                    w_perr_nxt  = 1'b0;
                    w_abt_nxt   = 1'b0;
                    w_stuck_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                if (i_abort) begin
                    w_state_nxt = ST_REPORT;
                    w_abt_nxt   = 1'b1;
                end else if (r_settle == '0) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // ACK outranks both ABORT and timeout on the same edge.
                if (i_bus_ack) begin
                    w_state_nxt = ST_RELEASE;
                    w_done_nxt  = 1'b1;
                    w_perr_nxt  = i_bus_par_err & ~o_bus_wr;
                end else if (i_abort) begin
                    w_state_nxt = ST_RELEASE;
                    w_abt_nxt   = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RELEASE;
                    w_nxm_nxt   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!i_bus_ack) begin
                    w_state_nxt = ST_REPORT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_REPORT;
                    w_stuck_nxt = 1'b1;
                end
            end
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_req_nxt    = (w_state_nxt == ST_REQ);
        w_ld_nxt     = (w_state_nxt == ST_REPORT);
        w_bus_wr_nxt = w_accept ? i_wr : o_bus_wr;
        w_sts_nxt    = o_sts;
        if (w_ld_nxt)
            w_sts_nxt = {w_abt_nxt, w_stuck_nxt, o_bus_wr, w_perr_nxt, w_nxm_nxt, w_done_nxt};
    end

endmodule

// File: tb/tb_xbus_cycle_seq.sv
// Self-checking bench for xbus_cycle_seq: directed scenarios plus randomized bus cycles
// compared against an edge-indexed timeline computed from the handshake rules.
module tb_xbus_cycle_seq;

    localparam int S = 2;
    localparam int T = 8;
    localparam int NONE = 999;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_wr = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_bus_ack = 1'b0;
    logic       i_bus_par_err = 1'b0;
    logic       o_busy, o_bus_req, o_bus_wr, o_sts_ld;
    logic [5:0] o_sts;

    int         n_chk = 0;
    int         n_err = 0;
    logic [5:0] exp_sts = 6'b0;

    xbus_cycle_seq #(.SETTLE(S), .TMO_MAX(T), .TMO_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_wr         (i_wr),
        .i_abort      (i_abort),
        .i_bus_ack    (i_bus_ack),
        .i_bus_par_err(i_bus_par_err),
        .o_busy       (o_busy),
        .o_bus_req    (o_bus_req),
        .o_bus_wr     (o_bus_wr),
        .o_sts        (o_sts),
        .o_sts_ld     (o_sts_ld)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge 0 is the edge that samples START. ACK is high on edges [a0, a0+alen),
    // ABORT on edge ab, a stray START on edge extra. par_sel: 0 low, 1 high, 2 random.
    task automatic run_txn(input int wr, input int a0, input int alen, input int ab,
                           input int extra, input int par_sel, input string name);
        bit         ackv[64];
        bit         parv[64];
        int         rel, rpt;
        bit         setup_abt, done, nxm, abt, stuck, perr;
        logic [5:0] new_sts;

        for (int e = 0; e < 64; e++) begin
            ackv[e] = (e >= a0) && (e < a0 + alen);
            parv[e] = (par_sel == 2) ? 1'($urandom_range(0, 1)) : (par_sel == 1);
        end
        setup_abt = 0; done = 0; nxm = 0; abt = 0; stuck = 0; perr = 0;
        rel = -1;
        if (ab >= 1 && ab <= S) begin
            setup_abt = 1;
            abt = 1;
            rpt = ab;
        end else begin
            rel = S + T;
            nxm = 1;
            for (int e = S + 1; e <= S + T; e++) begin
                if (ackv[e]) begin
                    rel = e; nxm = 0; done = 1; perr = parv[e] & (wr == 0);
                    break;
                end else if (e == ab) begin
                    rel = e; nxm = 0; abt = 1;
                    break;
                end
            end
            rpt = rel + T;
            stuck = 1;
            for (int e = rel + 1; e <= rel + T; e++) begin
                if (!ackv[e]) begin
                    rpt = e; stuck = 0;
                    break;
                end
            end
        end
        new_sts = {abt, stuck, 1'(wr), perr, nxm, done};

        for (int k = 0; k <= rpt + 2; k++) begin
            i_start       = (k == 0) || (k == extra && k <= rpt + 1);
            i_wr          = (k == 0) ? 1'(wr) : 1'($urandom_range(0, 1));
            i_bus_ack     = ackv[k];
            i_abort       = (k == ab);
            i_bus_par_err = parv[k];
            @(posedge i_clk);
            #1;
            chk($sformatf("%s req@%0d", name, k), 32'(o_bus_req),
                32'(!setup_abt && k >= S && k < rel));
            chk($sformatf("%s busy@%0d", name, k), 32'(o_busy), 32'(k <= rpt));
            chk($sformatf("%s ld@%0d", name, k), 32'(o_sts_ld), 32'(k == rpt));
            chk($sformatf("%s bus_wr@%0d", name, k), 32'(o_bus_wr), 32'(wr));
            chk($sformatf("%s sts@%0d", name, k), 32'(o_sts), 32'((k >= rpt) ? new_sts : exp_sts));
        end
        exp_sts       = new_sts;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_bus_ack     = 1'b0;
        i_bus_par_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst req", 32'(o_bus_req), 32'd0);
        chk("rst wr", 32'(o_bus_wr), 32'd0);
        chk("rst sts", 32'(o_sts), 32'd0);
        chk("rst ld", 32'(o_sts_ld), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        run_txn(0, 4, 2, NONE, 0, 0, "read_ok");
        run_txn(1, 5, 1, NONE, 0, 1, "wr_par");
        run_txn(0, 5, 1, NONE, 0, 1, "rd_par");
        run_txn(0, NONE, 0, NONE, 0, 0, "timeout");
        run_txn(0, 3, 40, NONE, 0, 0, "stuck");
        run_txn(1, NONE, 0, 1, 0, 0, "abort_setup");
        run_txn(0, NONE, 0, S, 0, 0, "abort_settle_end");
        run_txn(0, 4, 1, 4, 0, 0, "abort_ack");
        run_txn(1, NONE, 0, 6, 0, 0, "abort_req");
        run_txn(0, S + T, 3, NONE, 0, 0, "late_ack");
        run_txn(0, 4, 2, NONE, 3, 0, "start_busy");

        // START together with ABORT in IDLE, then ABORT alone: neither starts a cycle
        i_start = 1'b1; i_abort = 1'b1; i_wr = 1'b1;
        @(posedge i_clk); #1;
        chk("start_abort busy", 32'(o_busy), 32'd0);
        i_start = 1'b0;
        @(posedge i_clk); #1;
        chk("abort_idle busy", 32'(o_busy), 32'd0);
        chk("abort_idle sts", 32'(o_sts), 32'(exp_sts));
        i_abort = 1'b0;

        for (int n = 0; n < 200; n++) begin
            int wr, a0, alen, ab, extra;
            wr    = $urandom_range(0, 1);
            a0    = S - 1 + $urandom_range(0, T + 3);
            alen  = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(1, 4);
            ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S + T + 1) : NONE;
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S + T) : 0;
            run_txn(wr, a0, alen, ab, extra, 2, $sformatf("rnd%0d", n));
        end

        // Reset while BUS_REQ is high drops everything without waiting for a clock
        i_start = 1'b1; i_wr = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (S) @(posedge i_clk);
        #1;
        chk("pre_rst req", 32'(o_bus_req), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_rst req", 32'(o_bus_req), 32'd0);
        chk("mid_rst busy", 32'(o_busy), 32'd0);
        chk("mid_rst wr", 32'(o_bus_wr), 32'd0);
        chk("mid_rst sts", 32'(o_sts), 32'd0);
        chk("mid_rst ld", 32'(o_sts_ld), 32'd0);
        exp_sts = 6'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        run_txn(0, 4, 2, NONE, 0, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
